// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the core's MEM stage and a
// word-by-word request/acknowledge memory bus; lines are 4 words, refilled/evicted as bursts.
module dcache_ctrl #(
  parameter int unsigned LINE_NUM = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  input  logic        mem_ack
);

  localparam int unsigned IdxW = $clog2(LINE_NUM);
  localparam int unsigned TagW = 28 - IdxW;

  typedef enum logic [1:0] {StIdle, StWb, StFill} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [27:0]       req_line_q, req_line_d;
  logic [LINE_NUM-1:0] valid_q, valid_d;
  logic [LINE_NUM-1:0] dirty_q, dirty_d;
  logic [TagW-1:0]   tag_q  [LINE_NUM];
  logic [31:0]       data_q [LINE_NUM][4];

  logic [IdxW-1:0]   cpu_idx, req_idx, data_idx;
  logic [TagW-1:0]   cpu_tag, req_tag;
  logic [1:0]        cpu_off, data_off;
  logic [31:0]       data_wdata;
  logic              data_we, tag_we, cpu_req, hit;
  logic              unused_addr;

  assign cpu_off     = cpu_addr[3:2];
  assign cpu_idx     = cpu_addr[3+IdxW:4];
  assign cpu_tag     = cpu_addr[31:4+IdxW];
  assign req_idx     = req_line_q[IdxW-1:0];
  assign req_tag     = req_line_q[27:IdxW];
  assign unused_addr = ^cpu_addr[1:0];

  // Requests are masked while reset is held so the core sees no stall during reset.
  assign cpu_req = rst & (cpu_ren | cpu_wen);
  assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_line_d = req_line_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    data_idx   = cpu_idx;
    data_off   = cpu_off;
    data_wdata = cpu_din;
    cpu_stall  = 1'b0;
    cpu_dout   = '0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_dout   = '0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (hit) begin
            // A simultaneous read and write is treated as a write.
            if (cpu_wen) begin
              data_we           = 1'b1;
              dirty_d[cpu_idx]  = 1'b1;
            end else begin
              cpu_dout = data_q[cpu_idx][cpu_off];
            end
          end else begin
            cpu_stall  = 1'b1;
            req_line_d = cpu_addr[31:4];
            cnt_d      = 2'd0;
            state_d    = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? StWb : StFill;
          end
        end
      end
      StWb: begin
        cpu_stall = 1'b1;
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
        mem_dout  = data_q[req_idx][cnt_q];
        if (mem_ack) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StFill;
        end
      end
      StFill: begin
        cpu_stall = 1'b1;
        mem_cs    = 1'b1;
        mem_addr  = {req_tag, req_idx, cnt_q, 2'b00};
        if (mem_ack) begin
          data_we    = 1'b1;
          data_idx   = req_idx;
          data_off   = cnt_q;
          data_wdata = mem_din;
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b0;
            state_d          = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      req_line_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_line_q <= req_line_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_idx][data_off] <= data_wdata;
    if (tag_we)  tag_q[req_idx]             <= req_tag;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected bus words and load data are queued by the
// stimulus and consumed by an independent monitor watching bus acks and completed loads.
module tb_dcache_ctrl;

  localparam int unsigned LineNum = 64;

  logic        clk, rst;
  logic        cpu_ren, cpu_wen;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_stall;
  logic        mem_cs, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_dout, mem_din;

  dcache_ctrl #(.LINE_NUM(LineNum)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_ren  (cpu_ren),
    .cpu_wen  (cpu_wen),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_stall(cpu_stall),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mdl [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_cnt = 0;
  int          ack_gap = 1;
  int          gap;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : 32'h0;
  endfunction

  // Memory model: ack after ack_gap cycles of mem_cs, read data from the model.
  always @(posedge clk or negedge rst) begin
    if (!rst)        gap <= 0;
    else if (mem_cs) gap <= mem_ack ? 0 : gap + 1;
    else             gap <= 0;
  end
  assign mem_ack = mem_cs && (gap == ack_gap - 1);
  assign mem_din = (mem_cs && !mem_we) ? mdl_rd(mem_addr) : 32'h0;

  // Monitor
  logic        held_v = 1'b0;
  logic        held_we;
  logic [31:0] held_addr, held_dout;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_cs) begin
        if (held_v) begin
          check("bus_hold_addr", mem_addr, held_addr);
          check("bus_hold_we", {31'h0, mem_we}, {31'h0, held_we});
          check("bus_hold_dout", mem_dout, held_dout);
        end
        if (mem_ack) begin
          held_v = 1'b0;
          ack_cnt++;
          if (bus_q.size() == 0) begin
            check("bus_unexpected", mem_addr, 32'hFFFF_FFFF);
          end else begin
            bus_t e;
            e = bus_q.pop_front();
            check("bus_we", {31'h0, mem_we}, {31'h0, e.we});
            check("bus_addr", mem_addr, e.addr);
            if (e.we) check("bus_wdata", mem_dout, e.data);
          end
          if (mem_we) mdl[mem_addr] = mem_dout;
        end else begin
          held_v    = 1'b1;
          held_we   = mem_we;
          held_addr = mem_addr;
          held_dout = mem_dout;
        end
      end else begin
        held_v = 1'b0;
      end
      if (cpu_ren && !cpu_wen && !cpu_stall) begin
        if (rd_q.size() == 0) check("rd_unexpected", cpu_dout, 32'hFFFF_FFFF);
        else                  check("rd_data", cpu_dout, rd_q.pop_front());
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic exp_fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) bus_q.push_back('{we: 1'b0, addr: base + 32'(4 * i), data: 32'h0});
  endtask

  task automatic exp_wb(input logic [31:0] base, input logic [31:0] d0, d1, d2, d3);
    bus_q.push_back('{we: 1'b1, addr: base,         data: d0});
    bus_q.push_back('{we: 1'b1, addr: base + 32'd4, data: d1});
    bus_q.push_back('{we: 1'b1, addr: base + 32'd8, data: d2});
    bus_q.push_back('{we: 1'b1, addr: base + 32'd12, data: d3});
  endtask

  task automatic cpu_op(input string nm, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int exp_stall);
    int n;
    n = 0;
    @(posedge clk); #1;
    cpu_ren = r; cpu_wen = w; cpu_addr = a; cpu_din = d;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      n++;
      if (n > 200) begin
        $display("FAIL %s_timeout: stall still high after %0d cycles, expected %0d", nm, n,
                 exp_stall);
        n_fail++;
        break;
      end
    end
    check({nm, "_stall"}, 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    int start;
    rst = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_din = '0;
    for (int i = 0; i < 4; i++) begin
      mdl[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
      mdl[32'h500 + 32'(4 * i)] = 32'hB0 + 32'(i);
      mdl[32'h200 + 32'(4 * i)] = 32'hC0 + 32'(i);
      mdl[32'h600 + 32'(4 * i)] = 32'hE0 + 32'(i);
      mdl[32'h700 + 32'(4 * i)] = 32'hF0 + 32'(i);
    end
    repeat (2) @(negedge clk);
    check("rst_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_cpu_dout", cpu_dout, 32'h0);
    check("rst_mem_cs", {31'h0, mem_cs}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_dout", mem_dout, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_mem_cs", {31'h0, mem_cs}, 32'h0);

    // Cold read miss, then read hit.
    exp_fill(32'h100); rd_q.push_back(32'hA1);
    cpu_op("cold_miss", 1'b1, 1'b0, 32'h104, 32'h0, 5);
    rd_q.push_back(32'hA3);
    cpu_op("read_hit", 1'b1, 1'b0, 32'h10C, 32'h0, 0);

    // Write hit, then conflicting read forces write-back of the dirty line.
    cpu_op("write_hit", 1'b0, 1'b1, 32'h108, 32'hDEAD_BEEF, 0);
    exp_wb(32'h100, 32'hA0, 32'hA1, 32'hDEAD_BEEF, 32'hA3);
    exp_fill(32'h500); rd_q.push_back(32'hB2);
    cpu_op("dirty_miss", 1'b1, 1'b0, 32'h108 + LineNum * 16, 32'h0, 9);

    // Slow bus: ack every 4th cycle.
    pulse_reset();
    ack_gap = 4;
    exp_fill(32'h100); rd_q.push_back(32'hA1);
    cpu_op("slow_bus", 1'b1, 1'b0, 32'h104, 32'h0, 17);
    ack_gap = 1;

    // Write miss allocates, store lands after the fill, line becomes dirty.
    exp_fill(32'h200);
    cpu_op("write_miss", 1'b0, 1'b1, 32'h200, 32'h1234_5678, 5);
    rd_q.push_back(32'h1234_5678);
    cpu_op("alloc_hit", 1'b1, 1'b0, 32'h200, 32'h0, 0);
    exp_wb(32'h200, 32'h1234_5678, 32'hC1, 32'hC2, 32'hC3);
    exp_fill(32'h600); rd_q.push_back(32'hE0);
    cpu_op("alloc_evict", 1'b1, 1'b0, 32'h600, 32'h0, 9);

    // Reset after the second fill ack abandons the burst.
    exp_fill(32'h700);
    void'(bus_q.pop_back()); void'(bus_q.pop_back());
    start = ack_cnt;
    @(posedge clk); #1;
    cpu_ren = 1'b1; cpu_addr = 32'h704;
    for (int i = 0; i < 50 && ack_cnt < start + 2; i++) begin
      @(negedge clk); #1;
    end
    check("midfill_acks", 32'(ack_cnt - start), 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midfill_rst_cs", {31'h0, mem_cs}, 32'h0);
    check("midfill_rst_stall", {31'h0, cpu_stall}, 32'h0);
    cpu_ren = 1'b0;
    @(negedge clk); rst = 1'b1;
    exp_fill(32'h700); rd_q.push_back(32'hF1);
    cpu_op("after_rst", 1'b1, 1'b0, 32'h704, 32'h0, 5);

    repeat (3) @(negedge clk);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
